// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning HI/LO; optional exception flush input under MDU_CANCEL_EN.
// Result commits MULT_CYCLES/DIV_CYCLES edges after accept; requests arriving while busy are ignored.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          done_q, done_d;
  logic          flush;

`ifdef MDU_CANCEL_EN
  assign flush = cancel;
`else
  assign flush = 1'b0;
`endif

  // Datapath results, all derived from the operands present on the accepting edge.
  logic [63:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe, rt_safe;
  logic [31:0] q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

  always_comb begin
    a_sx     = {{32{rs_val[31]}}, rs_val};
    b_sx     = {{32{rt_val[31]}}, rt_val};
    a_zx     = {32'd0, rs_val};
    b_zx     = {32'd0, rt_val};
    prod_s   = a_sx * b_sx;
    prod_u   = a_zx * b_zx;
    div_zero = (rt_val == 32'd0);
    a_neg    = rs_val[31];
    b_neg    = rt_val[31];
    a_mag    = a_neg ? (32'd0 - rs_val) : rs_val;
    b_mag    = b_neg ? (32'd0 - rt_val) : rt_val;
    // Divisor is forced non-zero so the divider never sees 0; the result is discarded anyway.
    b_safe   = div_zero ? 32'd1 : b_mag;
    rt_safe  = div_zero ? 32'd1 : rt_val;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quo_s    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem_s    = a_neg ? (32'd0 - r_mag) : r_mag;
    quo_u    = rs_val / rt_safe;
    rem_u    = rs_val % rt_safe;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            OP_MULT, OP_MULTU: begin
              pend_hi_d = (op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
              pend_lo_d = (op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = (op == OP_DIV) ? rem_s : rem_u;
              pend_lo_d = (op == OP_DIV) ? quo_s : quo_u;
              pend_wr_d = !div_zero;
              cnt_d     = DIV_LOAD;
              state_d   = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_ONE) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit controller for the MIPS32 datapath.
- Accepts one mult/multu/div/divu/mthi/mtlo request per instruction and sequences the fixed-latency operation with a down-counter.
- Owns the HI/LO architectural registers and raises busy so the decode stage stalls dependent instructions (mfhi/mflo/next md op).

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range ≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range ≥1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request valid for this cycle.
- op  in  3  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=none.
- rs_val  in  32  operand A (dividend / mthi, mtlo source).
- rt_val  in  32  operand B (divisor).
- busy  out  1  operation in flight (registered).
- done  out  1  one-cycle pulse in the cycle HI/LO first shows a new mult/div result.
- hi  out  32  HI register.
- lo  out  32  LO register.
- cancel  in  1  present only with MDU_CANCEL_EN.

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, cnt=0, pending result cleared. Reset wins over every other input in the same cycle, including mid-operation; the in-flight op is discarded.
- Accept rule: start && busy==0 && op in 1..6. Requests with start while busy==1, or with op 0/7, are ignored with no side effects. Upstream must hold the request while stalled.
- mthi/mtlo: on the accepting edge, hi (or lo) <= rs_val. busy stays 0 and done stays 0.
- mult/multu/div/divu on the accepting edge:
  - Result is computed combinationally from rs_val/rt_val and latched into pend_hi/pend_lo.
  - cnt <= MULT_CYCLES or DIV_CYCLES; busy <= 1.
  - Operands may change afterwards without effect.
- Each subsequent edge with cnt>1: cnt <= cnt-1.
- Edge with cnt==1: hi<=pend_hi, lo<=pend_lo, cnt<=0, busy<=0, done<=1. done clears on the next edge.
- Net timing: busy is high for exactly N cycles. New hi/lo is visible in the first cycle with busy=0, coincident with done=1.
- A start in that same done cycle is accepted.
- A start in the last busy cycle (cnt==1) is ignored.
- mult: signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
- multu: same as mult, unsigned.
- div: signed, quotient truncates toward zero; lo = quotient, hi = remainder, remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu: unsigned; lo = quotient, hi = remainder.
- Divide by zero (rt_val==0, div or divu): normal busy/done timing, but hi/lo keep their prior values.
- cnt width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

Optional Feature:
- Macro MDU_CANCEL_EN.
- Defined: adds input cancel (1 bit) for exception flush.
  - cancel high on an edge with busy=1: cnt<=0, busy<=0, hi/lo unchanged, done stays 0.
  - cancel has priority over a concurrent cnt==1 commit.
  - If start and cancel are high together while busy=0, the request is dropped.
- Undefined: no cancel port; every accepted op always runs to completion.

Test Plan:
- Reset, then start op=1 (mult), rs=0xFFFFFFFD (-3), rt=5 -> busy high exactly 5 cycles; then done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- op=2 (multu), rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE. Additionally, assert start op=5 rs=0x1234 during busy -> hi is not changed to 0x1234.
- op=3 (div), rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then op=4 (divu), rs=7, rt=2 -> lo=3, hi=1.
- Preload via op=5 rs=0xAAAA and op=6 rs=0x5555 (no busy, values visible the next cycle). Then op=3, rt=0 -> done pulses after 10 cycles; hi=0xAAAA, lo=0x5555 unchanged.
- Start mult, assert reset on the 3rd busy cycle -> next cycle busy=0, done=0, hi=lo=0, and no late commit occurs.
- With MDU_CANCEL_EN: start div 100/7, pulse cancel on the 4th busy cycle -> busy=0 the next cycle, done never pulses, hi/lo unchanged.
